ps2_key_receiver: RTL
=====================

# ps2_key_receiver

Receives raw PS/2 keyboard clock/data, deframes 11-bit serial frames and folds the E0/F0 prefix bytes into complete key events. Sits directly upstream of `processor`. It drives the processor's `ps2_key_pressed` input with a one-cycle strobe and its 32-bit `ps2_out` input with a held key word. Single clock domain; the PS/2 lines are treated as asynchronous.

## Interface
- `TIMEOUT_CYCLES`, 50000: idle clocks inside a frame before the partial frame is aborted (1 ms at 50 MHz).
- `EMIT_BREAK`, 1: 1 = break (release) events are also strobed; 0 = only make events are strobed.
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `ps2_clock`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `ps2_key_pressed`  out  1  one-cycle strobe per completed key event.
- `ps2_out`  out  32  key word `{22'b0, brk, ext, code[7:0]}`; held until the next event.
- `frame_error`  out  1  one-cycle strobe on a parity error, a framing error or a timeout abort.

## Operation
- Synchronizer:
  - `ps2_clock` and `ps2_data` each pass through 2 flops; `ps2_clock` also gets a third history flop.
  - Falling edge = history 1 and synced 0.
  - Data is sampled from the synced `ps2_data` on the edge cycle.
- Frame FSM states: IDLE, RECV, CHECK.
  - IDLE: on a falling edge with data 0 (start bit) -> RECV, bitcnt=0. A start bit of 1 is ignored; stay IDLE.
  - RECV: each falling edge shifts the data bit in LSB-first. Bits 0-7 are data, bit 8 is parity, bit 9 is stop. After the stop bit -> CHECK.
  - CHECK, lasting one cycle:
    - Valid frame: odd parity over data+parity holds and stop = 1. The byte then goes to the decoder.
    - Otherwise: pulse `frame_error` and discard the byte.
    - Always return to IDLE.
- Timeout: a counter clears on every falling edge and counts in RECV. At TIMEOUT_CYCLES it pulses `frame_error`, returns to IDLE, and clears ext_pend and brk_pend.
- Prefix decoder:
  - byte E0: set ext_pend; no event.
  - byte F0: set brk_pend; no event.
  - any other byte: form the event `{brk_pend, ext_pend, byte}` and clear both flags.
    - If brk_pend = 0 or EMIT_BREAK = 1: load `ps2_out` and strobe.
    - A suppressed break still clears the flags and leaves `ps2_out` unchanged.
- A frame error also clears both flags, so a corrupted prefix never attaches to a later byte.
- There is no buffering: the processor samples the strobe. Back-to-back keys are at least 11 PS/2 clocks apart, far slower than `clock`.

## Timing
- Reset values: `ps2_key_pressed`=0, `ps2_out`=0, `frame_error`=0, FSM=IDLE, flags=0, counters=0, synchronizer flops=1 (idle bus level).
- Edge detect latency is 3 clocks from the pin falling edge to the edge cycle.
- `ps2_key_pressed` and `ps2_out` update on the same edge, exactly one cycle after CHECK. `ps2_key_pressed` is high for exactly 1 cycle.
- `frame_error` is asserted in the cycle after CHECK or timeout detection, for 1 cycle.
- Reset asserted mid-frame: everything returns to reset values immediately. After release, a frame already in flight is seen as a start bit only if its data is 0 on an edge. Typically it is corrupted and ends in a parity or framing error or a timeout, never in a strobe with wrong data.
- Timeout boundary: the abort fires when the counter reaches TIMEOUT_CYCLES. A falling edge in that same cycle wins: the counter clears and there is no abort.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`; it saturates and does not wrap.

## Test plan
- Make code 0x1C, 10 µs PS/2 period: one strobe; `ps2_out`=0x0000001C; `frame_error` stays 0.
- Sequence F0,1C with EMIT_BREAK=1: no strobe after F0; one strobe with `ps2_out`=0x0000021C. With EMIT_BREAK=0: no strobe, and `ps2_out` keeps its prior value 0x1C.
- Sequence E0,F0,75: one strobe, `ps2_out`=0x00000375. A following plain 0x75 gives `ps2_out`=0x00000075.
- 0x1C sent with even parity: `frame_error` pulses once, no strobe. A following valid 0x1B strobes 0x1B with no stale flags. E0 then a bad-parity frame, then 0x74: strobe 0x074, ext=0.
- Stop after 5 bits: after TIMEOUT_CYCLES+3 clocks `frame_error` pulses and the FSM is IDLE. The next valid frame 0x29 strobes 0x29.
- Assert `reset`=0 mid-frame for 2 cycles: all outputs 0 immediately. No strobe carrying partial data; the next clean frame 0x5A strobes 0x5A.

Source files
------------

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: deframes PS/2 keyboard frames and folds E0/F0 prefixes into key events.
module ps2_key_receiver #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit EMIT_BREAK     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clock,
  input  logic        ps2_data,
  output logic        ps2_key_pressed,
  output logic [31:0] ps2_out,
  output logic        frame_error
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
  state_t state_q, state_d;
  logic [2:0] ck_q;
  logic [1:0] dt_q;
  logic [3:0] bit_q, bit_d;
  logic [9:0] sh_q, sh_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic ext_q, ext_d, brk_q, brk_d, stb_d, err_d;
  logic [31:0] out_d;
  logic fall, dat, tmo_hit, valid;
  logic [7:0] rx_byte;
  assign fall = ck_q[2] & ~ck_q[1];
  assign dat = dt_q[1];
  assign tmo_hit = (state_q == RECV) && !fall && (tmo_q == TW'(TIMEOUT_CYCLES));
  // odd parity over data+parity, and stop bit high
  assign valid = (^sh_q[8:0]) & sh_q[9];
  assign rx_byte = sh_q[7:0];
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    sh_d = sh_q;
    ext_d = ext_q;
    brk_d = brk_q;
    stb_d = 1'b0;
    err_d = 1'b0;
    out_d = ps2_out;
    tmo_d = (fall || state_q != RECV) ? '0 :
            (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + 1'b1;
    case (state_q)
      IDLE: if (fall && !dat) begin
        state_d = RECV;
        bit_d = 4'd0;
      end
      RECV: if (tmo_hit) begin
        state_d = IDLE;
        err_d = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (fall) begin
        sh_d = {dat, sh_q[9:1]};
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'd9) state_d = CHECK;
      end
      CHECK: begin
        state_d = IDLE;
        if (!valid) begin
          err_d = 1'b1;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end else if (rx_byte == 8'hE0) ext_d = 1'b1;
        else if (rx_byte == 8'hF0) brk_d = 1'b1;
        else begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (!brk_q || EMIT_BREAK) begin
            stb_d = 1'b1;
            out_d = {22'b0, brk_q, ext_q, rx_byte};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ck_q <= 3'b111;
      dt_q <= 2'b11;
      state_q <= IDLE;
      bit_q <= '0;
      sh_q <= '0;
      tmo_q <= '0;
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      ps2_key_pressed <= 1'b0;
      ps2_out <= '0;
      frame_error <= 1'b0;
    end else begin
      ck_q <= {ck_q[1:0], ps2_clock};
      dt_q <= {dt_q[0], ps2_data};
      state_q <= state_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      tmo_q <= tmo_d;
      ext_q <= ext_d;
      brk_q <= brk_d;
      ps2_key_pressed <= stb_d;
      ps2_out <= out_d;
      frame_error <= err_d;
    end
  end
endmodule
